ram_master: RTL and testbench

- Bus initiator that drives the team's synchronous single-port RAM (addr / ce / rw / clr / bidirectional data).
- Converts single-cycle user requests (read, write, clear) into correctly sequenced RAM cycles, with a one-cycle done pulse on completion.
- Owns bus direction: drives data only during write cycles; otherwise high-impedance so the RAM can drive it.

---
 rtl/ram_master.sv | 115 +++++++++++
 tb/tb_ram_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
// ram_master: sequences single-cycle user requests (read, write, clear) into
// cycles on a synchronous single-port RAM and owns the shared data bus.
module ram_master #(
  parameter int unsigned n = 4,  // data bus width
  parameter int unsigned m = 3   // address width
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         req,
  input  logic         wr,
  input  logic [m-1:0] req_addr,
  input  logic [n-1:0] wdata,
  input  logic         clr_req,
  output logic         ready,
  output logic         done,
  output logic [n-1:0] rdata,
  output logic [m-1:0] ram_addr,
  output logic         ram_ce,
  output logic         ram_rw,
  output logic         ram_clr,
  inout  wire  [n-1:0] ram_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    CLR  = 3'd4
  } state_t;

  state_t         state_q;
  logic [m-1:0]   addr_q;
  logic [n-1:0]   data_q;
  logic [n-1:0]   rdata_q;
  logic           done_q;

  // Sequencer: accepts requests only in IDLE, captures read data at the RD2 edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLR;
          end else if (req) begin
            addr_q <= req_addr;
            if (wr) begin
              data_q  <= wdata;
              state_q <= WR;
            end else begin
              state_q <= RD1;
            end
          end
        end
        WR: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        RD1: begin
          state_q <= RD2;
        end
        RD2: begin
          rdata_q <= ram_data;
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        CLR: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM-side strobes decoded straight from the current state.
  always_comb begin
    ready   = 1'b0;
    ram_ce  = 1'b0;
    ram_rw  = 1'b1;
    ram_clr = 1'b1;
    case (state_q)
      IDLE: ready = 1'b1;
      WR: begin
        ram_ce = 1'b1;
        ram_rw = 1'b0;
      end
      RD1, RD2: ram_ce = 1'b1;
      CLR: begin
        ram_ce  = 1'b1;
        ram_clr = 1'b0;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // The bus is driven only while writing; the RAM drives it during reads.
  assign ram_data = (state_q == WR) ? data_q : {n{1'bz}};

  assign ram_addr = addr_q;
  assign rdata    = rdata_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: behavioural RAM on the shared bus, a cycle table for
// the basic protocol, and hand-written sequences for the multi-cycle cases.
module tb_ram_master;

  logic       clk;
  logic       clr;
  logic       req;
  logic       wr;
  logic [2:0] req_addr;
  logic [3:0] wdata;
  logic       clr_req;
  logic       ready;
  logic       done;
  logic [3:0] rdata;
  logic [2:0] ram_addr;
  logic       ram_ce;
  logic       ram_rw;
  logic       ram_clr;
  wire  [3:0] ram_data;

  int n_chk;
  int n_fail;
  logic [3:0] last_rdata;

  ram_master #(.n(4), .m(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .wr       (wr),
    .req_addr (req_addr),
    .wdata    (wdata),
    .clr_req  (clr_req),
    .ready    (ready),
    .done     (done),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_ce   (ram_ce),
    .ram_rw   (ram_rw),
    .ram_clr  (ram_clr),
    .ram_data (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Released bus floats high so a stray master drive is visible.
  for (genvar g = 0; g < 4; g++) begin : g_pu
    pullup (ram_data[g]);
  end

  // Behavioural synchronous RAM: output register loaded on a read edge and
  // driven for the single following cycle.
  logic [3:0] mem [8];
  logic [3:0] ram_dout;
  logic       ram_oe;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 4'h0;
    ram_dout = 4'h0;
    ram_oe   = 1'b0;
  end

  always @(posedge clk) begin
    if (!ram_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
    end else if (ram_ce && !ram_rw) begin
      mem[ram_addr] <= ram_data;
    end else if (ram_ce && ram_rw) begin
      ram_dout <= mem[ram_addr];
    end
    ram_oe <= ram_ce && ram_rw && ram_clr && !ram_oe;
  end

  assign ram_data = ram_oe ? ram_dout : 4'bzzzz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [3:0] d);
    req = 1'b1; wr = 1'b1; req_addr = a; wdata = d;
    tick();
    req = 1'b0;
    chk("wr_state", {29'd0, ram_ce, ram_rw, done}, 32'b100);
    tick();
    chk("wr_done", {31'd0, done}, 32'd1);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [3:0] exp);
    req = 1'b1; wr = 1'b0; req_addr = a;
    tick();
    req = 1'b0;
    chk("rd1_bus_rdata", {24'd0, ram_data, rdata}, {24'd0, 4'hF, last_rdata});
    tick();
    chk("rd2_bus_rdata", {24'd0, ram_data, rdata}, {24'd0, exp, last_rdata});
    tick();
    chk("rd_done", {27'd0, done, rdata}, {27'd0, 1'b1, exp});
    last_rdata = exp;
  endtask

  typedef struct {
    logic       req;
    logic       wr;
    logic       clr_req;
    logic [2:0] addr;
    logic [3:0] wd;
    logic [3:0] e_ctl;   // {ready, ce, rw, ram_clr}
    logic       e_done;
    logic [3:0] e_rdata;
    logic [2:0] e_addr;
    logic [3:0] e_bus;
  } vec_t;

  vec_t vecs [14];

  initial begin
    n_chk = 0;
    n_fail = 0;
    last_rdata = 4'h0;
    clr = 1'b1; req = 1'b0; wr = 1'b0; req_addr = 3'd0; wdata = 4'h0; clr_req = 1'b0;

    //             req   wr    clrq  addr  wd     ctl      done  rdata  addr  bus
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'd3, 4'hA, 4'b0101, 1'b0, 4'h0, 3'd3, 4'hA};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'b1011, 1'b1, 4'h0, 3'd3, 4'hF};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'd3, 4'h0, 4'b0111, 1'b0, 4'h0, 3'd3, 4'hF};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'd5, 4'h2, 4'b0111, 1'b0, 4'h0, 3'd3, 4'hA};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'b1011, 1'b1, 4'hA, 3'd3, 4'hF};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 3'd1, 4'h3, 4'b0110, 1'b0, 4'hA, 3'd3, 4'hF};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'b1011, 1'b1, 4'hA, 3'd3, 4'hF};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'd3, 4'h0, 4'b0111, 1'b0, 4'hA, 3'd3, 4'hF};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'b0111, 1'b0, 4'hA, 3'd3, 4'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'b1011, 1'b1, 4'h0, 3'd3, 4'hF};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'b1011, 1'b0, 4'h0, 3'd3, 4'hF};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 3'd5, 4'h0, 4'b0111, 1'b0, 4'h0, 3'd5, 4'hF};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'b0111, 1'b0, 4'h0, 3'd5, 4'h0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'b1011, 1'b1, 4'h0, 3'd5, 4'hF};

    // Reset state
    tick();
    tick();
    chk("reset", {16'd0, ready, ram_ce, ram_rw, ram_clr, done, rdata, ram_addr, ram_data},
         {16'd0, 4'b1011, 1'b0, 4'h0, 3'd0, 4'hF});
    clr = 1'b0;
    tick();

    // Cycle table: write/read, ignored requests, clear priority
    for (int i = 0; i < 14; i++) begin
      req = vecs[i].req; wr = vecs[i].wr; clr_req = vecs[i].clr_req;
      req_addr = vecs[i].addr; wdata = vecs[i].wd;
      tick();
      chk($sformatf("vec%0d", i),
          {16'd0, ready, ram_ce, ram_rw, ram_clr, done, rdata, ram_addr, ram_data},
          {16'd0, vecs[i].e_ctl, vecs[i].e_done, vecs[i].e_rdata, vecs[i].e_addr, vecs[i].e_bus});
    end
    req = 1'b0; wr = 1'b0; clr_req = 1'b0;
    last_rdata = 4'h0;

    // Fill and read back
    for (int k = 0; k < 8; k++) do_write(3'(k), 4'(k + 5));
    for (int k = 0; k < 8; k++) do_read(3'(k), 4'(k + 5));

    // Clear pulse, then everything reads zero
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_pulse", {29'd0, ram_ce, ram_clr, done}, 32'b100);
    tick();
    chk("clr_done", {26'd0, ram_clr, done, rdata}, {26'd0, 1'b1, 1'b1, 4'hC});
    tick();
    chk("clr_single", {30'd0, ram_clr, done}, 32'b10);
    for (int k = 0; k < 8; k++) do_read(3'(k), 4'h0);

    // Back-to-back writes with req held
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; wr = 1'b1; req_addr = 3'(i); wdata = 4'(i * 3 + 1);
      tick();
      chk($sformatf("b2b%0d", i), {29'd0, done, ram_ce, ram_rw},
          (i % 2 == 1) ? 32'b101 : 32'b010);
    end
    req = 1'b0;
    tick();
    do_read(3'd1, 4'h0);
    do_read(3'd3, 4'h0);
    do_read(3'd5, 4'h0);
    do_read(3'd7, 4'h0);
    do_read(3'd0, 4'h1);
    do_read(3'd2, 4'h7);
    do_read(3'd4, 4'hD);
    do_read(3'd6, 4'h3);

    // Asynchronous reset in the middle of RD1
    req = 1'b1; wr = 1'b0; req_addr = 3'd4;
    tick();
    req = 1'b0;
    #3 clr = 1'b1;
    #1;
    chk("rst_async", {19'd0, ready, ram_ce, done, rdata, ram_addr, ram_data},
        {19'd0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 4'hF});
    tick();
    chk("rst_held", {29'd0, ready, done, ram_ce}, 32'b100);
    clr = 1'b0;
    tick();
    chk("rst_no_done", {29'd0, ready, done, ram_ce}, 32'b100);
    last_rdata = 4'h0;
    do_read(3'd4, 4'hD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
